ddr_wrapp: RTL and testbench

Write-side user application for the Xilinx MIG native app interface, the counterpart of the existing DDR read app. It accepts a start address and burst count from the system side, then takes one beat per burst from an upstream ready/valid stream. It pushes each beat into the MIG write-data FIFO and issues one write command per beat. It reports busy and a one-cycle done pulse.

---
 rtl/ddr_app_pkg.sv | 18 +
 rtl/ddr_wrapp_if.sv | 40 ++++
 rtl/ddr_wrapp.sv | 81 ++++++++
 tb/tb_ddr_wrapp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
// Shared definitions for the DDR read/write apps on the MIG native interface:
// command encodings, app FSM states and default widths.
package ddr_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_BURST_L = 8;
  localparam int DEF_BL_W    = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WR   = 1'b1
  } app_state_t;

endpackage

// File: rtl/ddr_wrapp_if.sv
// Bundle of the system-side request/stream signals and the MIG native write port.
// The master drives requests, data and MIG readies; the slave is the write app.
interface ddr_wrapp_if
  import ddr_app_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BL_W   = DEF_BL_W
);
  logic              en;
  logic [BL_W-1:0]   bl;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dat_i;
  logic              dat_vld;
  logic              dat_rdy;
  logic              done;
  logic              busy;

  logic [2:0]          app_cmd;
  logic [ADDR_W-1:0]   app_addr;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_rdy;

  modport master (
    output en, bl, addr, dat_i, dat_vld, app_rdy, app_wdf_rdy,
    input  dat_rdy, done, busy, app_cmd, app_addr, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );

  modport slave (
    input  en, bl, addr, dat_i, dat_vld, app_rdy, app_wdf_rdy,
    output dat_rdy, done, busy, app_cmd, app_addr, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );
endinterface

// File: rtl/ddr_wrapp.sv
// MIG write app: one data beat + one write command per burst; first beat 1 cycle after en, done at N+2.
// Backpressure: app_wdf_rdy/dat_vld stall the data counter, app_rdy stalls the command counter and address.
module ddr_wrapp
  import ddr_app_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_L = DEF_BURST_L,
  parameter int BL_W    = DEF_BL_W
) (
  input logic        clk,
  input logic        rst_n,
  ddr_wrapp_if.slave bus
);

  app_state_t        state;
  logic [BL_W-1:0]   bl_reg;
  logic [BL_W-1:0]   wcnt;
  logic [BL_W-1:0]   ccnt;
  logic [ADDR_W-1:0] cmd_addr;
  logic              done_q;

  logic in_wr;
  logic dat_rdy;
  logic wr_fire;
  logic cmd_en;
  logic cmd_fire;

  assign in_wr    = (state == WR);
  assign dat_rdy  = in_wr & bus.app_wdf_rdy & (wcnt < bl_reg);
  assign wr_fire  = bus.dat_vld & dat_rdy;
  // Command k waits until beat k is already in the MIG write FIFO.
  assign cmd_en   = in_wr & (ccnt < wcnt);
  assign cmd_fire = cmd_en & bus.app_rdy;

  assign bus.dat_rdy      = dat_rdy;
  assign bus.app_wdf_wren = wr_fire;
  assign bus.app_wdf_end  = wr_fire;
  assign bus.app_wdf_data = bus.dat_i;
  assign bus.app_wdf_mask = '0;
  assign bus.app_cmd      = CMD_WRITE;
  assign bus.app_en       = cmd_en;
  assign bus.app_addr     = cmd_addr;
  assign bus.busy         = in_wr;
  assign bus.done         = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      bl_reg   <= BL_W'(1);
      wcnt     <= '0;
      ccnt     <= '0;
      cmd_addr <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.en && (bus.bl != '0)) begin
          state    <= WR;
          bl_reg   <= bus.bl;
          cmd_addr <= bus.addr;
          wcnt     <= '0;
          ccnt     <= '0;
        end
      end else begin
        if (wr_fire) begin
          wcnt <= wcnt + 1'b1;
        end
        if (cmd_fire) begin
          ccnt     <= ccnt + 1'b1;
          cmd_addr <= cmd_addr + ADDR_W'(BURST_L);
          if (ccnt == bl_reg - 1'b1) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_wrapp.sv
// Bench for ddr_wrapp: table of transfers with a data/address scoreboard,
// plus hand sequences for reset state and bl=0 requests.
module tb_ddr_wrapp;
  import ddr_app_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int BL_W   = 8;

  logic clk;
  logic rst_n;

  ddr_wrapp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BL_W(BL_W)) bus ();

  ddr_wrapp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_L(8), .BL_W(BL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              bl;
    logic [27:0]     addr;
    int              vmode;     // 1: dat_vld gapped
    int              wmode;     // 1: app_wdf_rdy toggling
    int              stall;     // app_rdy low through this cycle
    bit              en_mid;    // second en with other addr during WR
    int              rst_after; // assert reset after this many beats (0: never)
    int              exp_done;  // expected done cycle (0: not checked)
    int              exp_busy;  // expected busy cycles (0: not checked)
  } vec_t;

  vec_t vecs[8];

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_data_q[$];
  logic [27:0]  exp_addr_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input int id, input int k);
    return {32'hDA7A0000 ^ 32'(id), 32'(k), ~32'(k), 32'(id * 1000 + k)};
  endfunction

  task automatic run_case(input int id, input vec_t v);
    int beats = 0;
    int cmds = 0;
    int busy_n = 0;
    int done_n = 0;
    int done_at = 0;
    bit stall_prev = 1'b0;
    logic [27:0] prev_addr = '0;
    bit finished = 1'b0;
    bit aborted = 1'b0;
    int exp_beats;

    for (int i = 0; i < v.bl; i++) begin
      exp_data_q.push_back(beat_data(id, i));
      exp_addr_q.push_back(v.addr + 28'(i * 8));
    end

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(posedge clk);
      #1;
      bus.en          = (cyc == 0) || (v.en_mid && cyc == 2);
      bus.bl          = (cyc == 0) ? BL_W'(v.bl) : BL_W'(7);
      bus.addr        = (cyc == 0) ? v.addr : (v.addr ^ 28'h5550);
      bus.dat_i       = beat_data(id, beats);
      bus.dat_vld     = (beats < v.bl) && (v.vmode == 0 || (cyc % 3) != 0);
      bus.app_wdf_rdy = (v.wmode == 0) || (cyc % 2 == 1);
      bus.app_rdy     = (cyc > v.stall);

      @(negedge clk);
      if (!bus.app_wdf_rdy) chk("dat_rdy_while_fifo_full", bus.dat_rdy, 1'b0);
      if (bus.app_en) begin
        if (stall_prev) chk("addr_stable_in_stall", bus.app_addr, prev_addr);
        if (bus.app_rdy) begin
          chk("cmd_after_data", (cmds < beats), 1'b1);
          chk("app_cmd", bus.app_cmd, CMD_WRITE);
          if (exp_addr_q.size() == 0) chk("addr_sb_underflow", 1'b1, 1'b0);
          else chk("cmd_addr", bus.app_addr, exp_addr_q.pop_front());
          cmds++;
        end
      end
      if (bus.app_wdf_wren) begin
        chk("wdf_end", bus.app_wdf_end, 1'b1);
        if (exp_data_q.size() == 0) chk("data_sb_underflow", 1'b1, 1'b0);
        else chk("wdf_data", bus.app_wdf_data, exp_data_q.pop_front());
        beats++;
      end
      stall_prev = bus.app_en && !bus.app_rdy;
      prev_addr  = bus.app_addr;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_at = cyc;
        chk("busy_low_at_done", bus.busy, 1'b0);
      end
      if (done_n > 0 && cyc == done_at + 1) finished = 1'b1;

      if (v.rst_after != 0 && beats == v.rst_after) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_dat_rdy", bus.dat_rdy, 1'b0);
        chk("rst_app_en", bus.app_en, 1'b0);
        chk("rst_wren", bus.app_wdf_wren, 1'b0);
        chk("rst_addr", bus.app_addr, 28'h0);
        for (int r = 0; r < 2; r++) begin
          @(negedge clk);
          chk("rst_no_done", bus.done, 1'b0);
        end
        rst_n = 1'b1;
        exp_data_q.delete();
        exp_addr_q.delete();
        aborted  = 1'b1;
        finished = 1'b1;
      end
    end

    bus.en = 1'b0;
    bus.dat_vld = 1'b0;
    exp_beats = aborted ? v.rst_after : v.bl;
    if (!finished) chk("timeout", 1'b1, 1'b0);
    chk("done_count", 128'(done_n), aborted ? 128'd0 : 128'd1);
    chk("beat_count", 128'(beats), 128'(exp_beats));
    if (!aborted) begin
      chk("cmd_count", 128'(cmds), 128'(v.bl));
      chk("sb_empty", 128'(exp_data_q.size() + exp_addr_q.size()), 128'd0);
    end
    if (v.exp_done != 0) chk("done_cycle", 128'(done_at), 128'(v.exp_done));
    if (v.exp_busy != 0) chk("busy_cycles", 128'(busy_n), 128'(v.exp_busy));
  endtask

  initial begin
    //            bl  addr          vm wm stall mid rst done busy
    vecs[0] = '{ 4, 28'h0000100,  0, 0, 0,    0,  0,  6,   5 };
    vecs[1] = '{ 3, 28'h0000000,  0, 0, 8,    0,  0,  12,  11 };
    vecs[2] = '{ 4, 28'h0000040,  1, 1, 0,    0,  0,  0,   0 };
    vecs[3] = '{ 4, 28'h0000200,  0, 0, 0,    1,  0,  6,   5 };
    vecs[4] = '{ 2, 28'hFFFFFF8,  0, 0, 0,    0,  0,  4,   3 };
    vecs[5] = '{ 5, 28'h0000300,  0, 0, 0,    0,  2,  0,   0 };
    vecs[6] = '{ 1, 28'h0000080,  0, 0, 0,    0,  0,  3,   2 };
    vecs[7] = '{ 20, 28'h0001000, 0, 1, 3,    0,  0,  0,   0 };

    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.bl          = '0;
    bus.addr        = '0;
    bus.dat_i       = '0;
    bus.dat_vld     = 1'b1;
    bus.app_rdy     = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_app_en", bus.app_en, 1'b0);
    chk("reset_dat_rdy", bus.dat_rdy, 1'b0);
    chk("reset_wren", bus.app_wdf_wren, 1'b0);
    chk("reset_addr", bus.app_addr, 28'h0);
    chk("reset_mask", bus.app_wdf_mask, 16'h0);
    rst_n = 1'b1;
    bus.dat_vld = 1'b0;

    // bl=0 request must be ignored entirely
    @(posedge clk);
    #1;
    bus.en   = 1'b1;
    bus.bl   = '0;
    bus.addr = 28'h500;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bl0_busy", bus.busy, 1'b0);
      chk("bl0_app_en", bus.app_en, 1'b0);
      chk("bl0_done", bus.done, 1'b0);
    end

    for (int i = 0; i < 8; i++) run_case(i, vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
